// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares a single memory port between an instruction-fetch requester (if_*)
// and a load/store requester (ls_*). At most one bus transaction is in flight.
// A three-state FSM (IDLE -> REQ -> WAIT -> IDLE) sequences each transaction:
//   IDLE : pick a winner and latch its command into the bus registers
//   REQ  : bus_req_o is high; the owner's gnt_o mirrors bus_gnt_i
//   WAIT : the first bus_rvalid_i is routed back to the owner
// When both requesters ask at once, the one that did not own the previous
// transaction wins; the owner register comes out of reset as load/store, so
// fetch wins the first tie.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   if_req_i/if_addr_i    fetch read request and address
//   if_gnt_o/if_rvalid_o/if_rdata_o/if_err_o   fetch acceptance and response
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i/ls_wstrb_i   load/store command
//   ls_gnt_o/ls_rvalid_o/ls_rdata_o/ls_err_o   load/store acceptance/response
//   bus_req_o/bus_we_o/bus_addr_o/bus_wdata_o/bus_wstrb_o   shared command
//   bus_gnt_i/bus_rvalid_i/bus_rdata_i/bus_err_i            shared response
//
// Optional feature
//   BUS_ARB_TIMEOUT_EN : when defined, a WAIT that lasts TIMEOUT_CYC cycles
//   without a response is closed with an error response to the owner.
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = `XLEN,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_err_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wstrb_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                ls_err_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_err_i
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYC must be at least 1");
  end

  state_t              state_q, state_d;
  logic                owner_q, owner_d;      // current / last owner
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;

  logic                winner_s;
  logic                resp_s;   // real response accepted this cycle
  logic                tmo_s;    // synthetic timeout response this cycle
  logic                done_s;

  // A response only counts while a transaction is actually waiting for one.
  assign resp_s = (state_q == WAIT) && bus_rvalid_i;
  assign done_s = resp_s || tmo_s;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // WAIT-cycle counter: held at zero outside WAIT, so it is clear on WAIT entry.
  always_comb begin
    cnt_d = {CNT_W{1'b0}};
    tmo_s = 1'b0;
    if (state_q == WAIT) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
      // A genuine response in the same cycle takes precedence over the timeout.
      tmo_s = !bus_rvalid_i && (cnt_q == CNT_W'(TIMEOUT_CYC));
    end else begin
      cnt_d = {CNT_W{1'b0}};
      tmo_s = 1'b0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

  // Next-state, round-robin pick and command latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    winner_s    = owner_q;

    // On a tie the requester that did not own the last transaction wins.
    if (if_req_i && ls_req_i) begin
      winner_s = (owner_q == OWN_LS) ? OWN_IF : OWN_LS;
    end else if (if_req_i) begin
      winner_s = OWN_IF;
    end else begin
      winner_s = OWN_LS;
    end

    case (state_q)
      IDLE: begin
        if (if_req_i || ls_req_i) begin
          state_d = REQ;
          owner_d = winner_s;
          if (winner_s == OWN_IF) begin
            // Fetches are always plain reads.
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr_i;
            bus_wdata_d = {DATA_W{1'b0}};
            bus_wstrb_d = {STRB_W{1'b0}};
          end else begin
            bus_we_d    = ls_we_i;
            bus_addr_d  = ls_addr_i;
            bus_wdata_d = ls_wdata_i;
            bus_wstrb_d = ls_wstrb_i;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // The latched command stays on the bus even if the requester drops req.
        if (bus_gnt_i) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (done_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bus_req_d = (state_d == REQ);
  end

  // FSM state, owner and registered bus command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_LS;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= {ADDR_W{1'b0}};
      bus_wdata_q <= {DATA_W{1'b0}};
      bus_wstrb_q <= {STRB_W{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_wstrb_o = bus_wstrb_q;

  // Grants and responses are steered to the owner only; the other side sees 0.
  assign if_gnt_o    = (state_q == REQ) && (owner_q == OWN_IF) && bus_gnt_i;
  assign ls_gnt_o    = (state_q == REQ) && (owner_q == OWN_LS) && bus_gnt_i;

  assign if_rvalid_o = done_s && (owner_q == OWN_IF);
  assign ls_rvalid_o = done_s && (owner_q == OWN_LS);

  assign if_err_o    = (owner_q == OWN_IF) && (tmo_s || (resp_s && bus_err_i));
  assign ls_err_o    = (owner_q == OWN_LS) && (tmo_s || (resp_s && bus_err_i));

  // Read data is zero on a timeout and whenever no response is being returned.
  assign if_rdata_o  = (resp_s && (owner_q == OWN_IF)) ? bus_rdata_i : {DATA_W{1'b0}};
  assign ls_rdata_o  = (resp_s && (owner_q == OWN_LS)) ? bus_rdata_i : {DATA_W{1'b0}};

endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o, if_rvalid_o, if_err_o;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i, ls_we_i;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i;
  logic [SW-1:0] ls_wstrb_i;
  logic          ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [DW-1:0] ls_rdata_o;
  logic          bus_req_o, bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [SW-1:0] bus_wstrb_o;
  logic          bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [DW-1:0] bus_rdata_i;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wstrb_i(ls_wstrb_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } cmd_t;

  typedef struct {
    logic          owner;   // 0 = fetch, 1 = load/store
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic model_last;          // reference round-robin state

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] out_or();
    return 64'({if_gnt_o, if_rvalid_o, |if_rdata_o, if_err_o,
                ls_gnt_o, ls_rvalid_o, |ls_rdata_o, ls_err_o,
                bus_req_o, bus_we_o, |bus_addr_o, |bus_wdata_o, |bus_wstrb_o});
  endfunction

  function automatic logic model_pick();
    if (if_req_i && ls_req_i) return (model_last == 1'b1) ? 1'b0 : 1'b1;
    else if (if_req_i) return 1'b0;
    else return 1'b1;
  endfunction

  task automatic push_rsp(input logic owner, input logic [DW-1:0] rdata, input logic err);
    rsp_t r;
    r.owner = owner;
    r.rdata = rdata;
    r.err   = err;
    rsp_q.push_back(r);
  endtask

  // Pop the oldest expected response and compare both requester sides.
  task automatic pop_rsp(input string tag);
    rsp_t r;
    if (rsp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 64'(rsp_q.size()), 64'h1);
    end else begin
      r = rsp_q.pop_front();
      check_eq({tag, "_rvalid"}, 64'({ls_rvalid_o, if_rvalid_o}), 64'(r.owner ? 2'b10 : 2'b01));
      check_eq({tag, "_if_rdata"}, 64'(if_rdata_o), 64'(r.owner ? 32'h0 : r.rdata));
      check_eq({tag, "_ls_rdata"}, 64'(ls_rdata_o), 64'(r.owner ? r.rdata : 32'h0));
      check_eq({tag, "_err"}, 64'({ls_err_o, if_err_o}),
               64'(r.err ? (r.owner ? 2'b10 : 2'b01) : 2'b00));
    end
  endtask

  // One transaction starting in IDLE with the request inputs already driven.
  // gnt_wait REQ cycles pass without grant, during which the winner drops its
  // request and scribbles its attributes; hold keeps req high after grant.
  task automatic run_txn(input logic [DW-1:0] rdata, input logic err,
                         input int gnt_wait, input bit hold);
    cmd_t c;
    cmd_t e;
    logic win;
    win = model_pick();
    model_last = win;
    if (win == 1'b0) c = '{1'b0, if_addr_i, {DW{1'b0}}, {SW{1'b0}}};
    else             c = '{ls_we_i, ls_addr_i, ls_wdata_i, ls_wstrb_i};
    cmd_q.push_back(c);
    #1;
    check_eq("req_idle", 64'(bus_req_o), 64'h0);
    tick();
    for (int i = 0; i < gnt_wait; i++) begin
      if (win == 1'b0) begin
        if_req_i  = 1'b0;
        if_addr_i = 32'hBAD0_0000;
      end else begin
        ls_req_i   = 1'b0;
        ls_addr_i  = 32'hBAD0_0004;
        ls_wdata_i = 32'h0BAD_F00D;
        ls_we_i    = ~ls_we_i;
      end
      #1;
      check_eq("req_hold", 64'(bus_req_o), 64'h1);
      check_eq("gnt_early", 64'({ls_gnt_o, if_gnt_o}), 64'h0);
      tick();
    end
    bus_gnt_i = 1'b1;
    #1;
    check_eq("bus_req", 64'(bus_req_o), 64'h1);
    e = cmd_q.pop_front();
    check_eq("bus_we", 64'(bus_we_o), 64'(e.we));
    check_eq("bus_addr", 64'(bus_addr_o), 64'(e.addr));
    check_eq("bus_wdata", 64'(bus_wdata_o), 64'(e.wdata));
    check_eq("bus_wstrb", 64'(bus_wstrb_o), 64'(e.wstrb));
    check_eq("gnt", 64'({ls_gnt_o, if_gnt_o}), 64'(win ? 2'b10 : 2'b01));
    tick();
    bus_gnt_i = 1'b0;
    if (!hold) begin
      if (win == 1'b0) if_req_i = 1'b0;
      else             ls_req_i = 1'b0;
    end
    #1;
    check_eq("req_off", 64'(bus_req_o), 64'h0);
    check_eq("gnt_pulse", 64'({ls_gnt_o, if_gnt_o}), 64'h0);
    check_eq("wait_quiet", 64'({ls_rvalid_o, if_rvalid_o}), 64'h0);
    tick();
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = rdata;
    bus_err_i    = err;
    push_rsp(win, rdata, err);
    #1;
    pop_rsp("rsp");
    tick();
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = {DW{1'b0}};
    bus_err_i    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rv;
    int seen_at;
    reset = 1'b0; model_last = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_wstrb_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;
    #3;
    check_eq("rst_quiet", out_or(), 64'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Fetch only.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    run_txn(32'h0000_0013, 1'b0, 0, 1'b0);

    // Store answered with a bus error.
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h0000_2004;
    ls_wdata_i = 32'hDEAD_BEEF; ls_wstrb_i = 4'hF;
    run_txn(32'h0000_5A5A, 1'b1, 0, 1'b0);

    // Reset in IDLE, then a three-transaction tie: fetch, load/store, fetch.
    reset = 1'b0; model_last = 1'b1;
    #1;
    check_eq("rst_idle_quiet", out_or(), 64'h0);
    tick();
    reset = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0400;
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h0000_3000;
    ls_wdata_i = 32'h1234_5678; ls_wstrb_i = 4'h3;
    run_txn(32'h1111_1111, 1'b0, 0, 1'b1);
    run_txn(32'h2222_2222, 1'b0, 0, 1'b1);
    run_txn(32'h3333_3333, 1'b0, 0, 1'b1);
    if_req_i = 1'b0; ls_req_i = 1'b0;

    // Load whose requester drops req before grant; attributes then change.
    tick();
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h0000_8000;
    ls_wdata_i = 32'h0; ls_wstrb_i = 4'h0;
    run_txn(32'h0000_CAFE, 1'b0, 2, 1'b0);
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0;

    // Reset pulled in WAIT; a response after release must be ignored.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0500;
    tick();
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0; if_req_i = 1'b0;
    #1;
    reset = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_0077;
    model_last = 1'b1;
    #1;
    check_eq("rst_wait_quiet", out_or(), 64'h0);
    tick();
    reset = 1'b1;
    #1;
    check_eq("late_rsp_ignored", 64'({ls_rvalid_o, if_rvalid_o}), 64'h0);
    tick();
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    tick();

    // Transaction whose response never arrives.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0600;
    tick();
    bus_gnt_i = 1'b1;
    #1;
    check_eq("tmo_gnt", 64'(if_gnt_o), 64'h1);
    tick();
    bus_gnt_i = 1'b0; if_req_i = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    push_rsp(1'b0, 32'h0, 1'b1);
    seen_at = -1;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (seen_at < 0 && (if_rvalid_o || ls_rvalid_o)) begin
        seen_at = i;
        pop_rsp("tmo");
      end
      tick();
    end
    check_eq("tmo_cycles", 64'(seen_at), 64'd5);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_0099;
    #1;
    check_eq("tmo_late_ignored", 64'({ls_rvalid_o, if_rvalid_o}), 64'h0);
    tick();
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
`else
    n_rv = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (if_rvalid_o || ls_rvalid_o) n_rv++;
      tick();
    end
    check_eq("no_tmo_rvalid", 64'(n_rv), 64'h0);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_0099;
    push_rsp(1'b0, 32'h0000_0099, 1'b0);
    #1;
    pop_rsp("slow_rsp");
    tick();
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
